// File: rtl/useq_ctrl_store.sv
// Microsequencer with a writable control store: steps through microwords that carry
// a datapath control field plus a sequencing op (branch, dispatch, call/return, halt).
module useq_ctrl_store #(
    parameter int UADDR_W    = 6,
    parameter int DEPTH      = 64,
    parameter int CTRL_W     = 32,
    parameter int NFLAGS     = 4,
    parameter int STACK_D    = 2,
    parameter int START_ADDR = 0,
    localparam int FSEL_W    = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
    localparam int W         = UADDR_W + 3 + FSEL_W + 1 + CTRL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NFLAGS-1:0]  flags,
    input  logic [UADDR_W-1:0] opcode,
    input  logic               wr_en,
    input  logic [UADDR_W-1:0] wr_addr,
    input  logic [W-1:0]       wr_data,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic [UADDR_W-1:0] upc,
    output logic               busy,
    output logic               finish,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_HALT     = 3'b000,
        OP_NEXT     = 3'b001,
        OP_JUMP     = 3'b010,
        OP_BRANCH   = 3'b011,
        OP_DISPATCH = 3'b100,
        OP_CALL     = 3'b101,
        OP_RET      = 3'b110,
        OP_RSVD     = 3'b111
    } seq_op_t;

    localparam int                 SP_W      = $clog2(STACK_D + 1);
    localparam int                 FEXT      = 2 ** FSEL_W;
    localparam logic [UADDR_W:0]   DEPTH_V   = (UADDR_W + 1)'(DEPTH);
    localparam logic [UADDR_W-1:0] LAST_ADDR = UADDR_W'(DEPTH - 1);
    localparam logic [UADDR_W-1:0] START_V   = UADDR_W'(START_ADDR);
    localparam logic [SP_W-1:0]    SP_FULL   = SP_W'(STACK_D);

    state_t             state_reg;
    logic [UADDR_W-1:0] upc_reg;
    logic [SP_W-1:0]    sp_reg;
    logic               busy_reg;
    logic               finish_reg;
    logic               err_reg;
    logic [UADDR_W-1:0] stack_reg [STACK_D];

    logic [W-1:0]       store_mem [DEPTH];

    logic [W-1:0]       word;
    logic [UADDR_W-1:0] next_addr;
    seq_op_t            seq_op;
    logic [FSEL_W-1:0]  cond_sel;
    logic               cond_pol;
    logic [CTRL_W-1:0]  ctrl_field;
    logic [FEXT-1:0]    flags_ext;
    logic               cond;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] pop_val;

    // Store is deliberately not reset so microcode survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en && (state_reg != ST_RUN) && ({1'b0, wr_addr} < DEPTH_V)) begin
            store_mem[wr_addr] <= wr_data;
        end
    end

    // Out-of-range micro-addresses read as zero, which decodes as HALT.
    assign word       = ({1'b0, upc_reg} < DEPTH_V) ? store_mem[upc_reg] : '0;
    assign next_addr  = word[W-1 -: UADDR_W];
    assign seq_op     = seq_op_t'(word[W-UADDR_W-1 -: 3]);
    assign cond_sel   = word[CTRL_W+1 +: FSEL_W];
    assign cond_pol   = word[CTRL_W];
    assign ctrl_field = word[CTRL_W-1:0];

    // Pad the flag vector so that unimplemented selects read as 0.
    generate
        for (genvar gi = 0; gi < FEXT; gi++) begin : g_flag_ext
            if (gi < NFLAGS) begin : g_real
                assign flags_ext[gi] = flags[gi];
            end else begin : g_pad
                assign flags_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign cond    = (flags_ext[cond_sel] == cond_pol);
    assign upc_inc = (upc_reg == LAST_ADDR) ? '0 : upc_reg + UADDR_W'(1);

    always_comb begin
        pop_val = '0;
        for (int i = 0; i < STACK_D; i++) begin
            if (sp_reg == SP_W'(i + 1)) begin
                pop_val = stack_reg[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            upc_reg    <= START_V;
            sp_reg     <= '0;
            busy_reg   <= 1'b0;
            finish_reg <= 1'b0;
            err_reg    <= 1'b0;
            for (int i = 0; i < STACK_D; i++) begin
                stack_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state_reg  <= ST_RUN;
                        upc_reg    <= START_V;
                        sp_reg     <= '0;
                        err_reg    <= 1'b0;
                        busy_reg   <= 1'b1;
                        finish_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    case (seq_op)
                        OP_HALT: begin
                            state_reg  <= ST_HALTED;
                            busy_reg   <= 1'b0;
                            finish_reg <= 1'b1;
                        end
                        OP_NEXT:     upc_reg <= upc_inc;
                        OP_JUMP:     upc_reg <= next_addr;
                        OP_BRANCH:   upc_reg <= cond ? next_addr : upc_inc;
                        OP_DISPATCH: upc_reg <= opcode;
                        OP_CALL: begin
                            if (sp_reg < SP_FULL) begin
                                for (int i = 0; i < STACK_D; i++) begin
                                    if (sp_reg == SP_W'(i)) begin
                                        stack_reg[i] <= upc_inc;
                                    end
                                end
                                sp_reg  <= sp_reg + SP_W'(1);
                                upc_reg <= next_addr;
                            end else begin
                                state_reg  <= ST_HALTED;
                                busy_reg   <= 1'b0;
                                finish_reg <= 1'b1;
                                err_reg    <= 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (sp_reg != '0) begin
                                sp_reg  <= sp_reg - SP_W'(1);
                                upc_reg <= pop_val;
                            end else begin
                                state_reg  <= ST_HALTED;
                                busy_reg   <= 1'b0;
                                finish_reg <= 1'b1;
                                err_reg    <= 1'b1;
                            end
                        end
                        default: begin
                            state_reg  <= ST_HALTED;
                            busy_reg   <= 1'b0;
                            finish_reg <= 1'b1;
                            err_reg    <= 1'b1;
                        end
                    endcase
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    busy_reg   <= 1'b0;
                    finish_reg <= 1'b0;
                end
            endcase
        end
    end

    // busy_reg clears asynchronously on reset, so the control bus drops at once.
    assign ctrl_out = busy_reg ? ctrl_field : '0;
    assign upc      = upc_reg;
    assign busy     = busy_reg;
    assign finish   = finish_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_useq_ctrl_store.sv
// Directed bench for useq_ctrl_store: per-cycle vector tables for each microprogram
// plus hand sequences for write-during-run, asynchronous reset and start-with-write.
module tb_useq_ctrl_store;

    localparam logic [2:0] HALT = 3'b000, NEXT = 3'b001, JUMP = 3'b010, BRANCH = 3'b011;
    localparam logic [2:0] DISPATCH = 3'b100, CALL = 3'b101, RET = 3'b110, RSVD = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  flags;
    logic [5:0]  opcode;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [43:0] wr_data;
    logic [31:0] ctrl_out;
    logic [5:0]  upc;
    logic        busy;
    logic        finish;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          phase;
        logic        start;
        logic [3:0]  flags;
        logic [5:0]  opcode;
        logic [31:0] ctrl;
        logic [5:0]  upc;
        logic        busy;
        logic        finish;
        logic        err;
        logic        chk_st;
    } vec_t;

    vec_t vecs[$];

    useq_ctrl_store #(
        .UADDR_W(6), .DEPTH(64), .CTRL_W(32), .NFLAGS(4), .STACK_D(2), .START_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .flags(flags), .opcode(opcode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ctrl_out(ctrl_out), .upc(upc), .busy(busy), .finish(finish), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] mw(input logic [5:0] na, input logic [2:0] op,
                                       input logic [1:0] sel, input logic pol,
                                       input logic [31:0] c);
        return {na, op, sel, pol, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input int p, input logic s, input logic [3:0] f, input logic [5:0] op,
                       input logic [31:0] c, input logic [5:0] u, input logic b,
                       input logic fi, input logic e, input logic cs);
        vec_t v;
        v.phase = p; v.start = s; v.flags = f; v.opcode = op; v.ctrl = c; v.upc = u;
        v.busy = b; v.finish = fi; v.err = e; v.chk_st = cs;
        vecs.push_back(v);
    endtask

    task automatic load(input logic [5:0] a, input logic [43:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic edge_step();
        @(posedge clk); #1;
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                start = vecs[i].start; flags = vecs[i].flags; opcode = vecs[i].opcode;
                @(posedge clk); #1;
                start = 1'b0;
                $display("phase %0d vec %0d: upc=%0d ctrl=%h busy=%b finish=%b err=%b",
                         p, i, upc, ctrl_out, busy, finish, err);
                chk($sformatf("p%0d_v%0d_ctrl", p, i), ctrl_out, vecs[i].ctrl);
                chk($sformatf("p%0d_v%0d_upc", p, i), 32'(upc), 32'(vecs[i].upc));
                if (vecs[i].chk_st) begin
                    chk($sformatf("p%0d_v%0d_busy", p, i), 32'(busy), 32'(vecs[i].busy));
                    chk($sformatf("p%0d_v%0d_finish", p, i), 32'(finish), 32'(vecs[i].finish));
                    chk($sformatf("p%0d_v%0d_err", p, i), 32'(err), 32'(vecs[i].err));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // phase 1: NEXT, NEXT, HALT; restart from HALTED; start held in RUN ignored
        add(1, 1, 4'h0, 6'd0, 32'h11, 6'd0, 1, 0, 0, 1);
        add(1, 0, 4'h0, 6'd0, 32'h22, 6'd1, 1, 0, 0, 1);
        add(1, 0, 4'h0, 6'd0, 32'h00, 6'd2, 0, 0, 0, 0);
        add(1, 0, 4'h0, 6'd0, 32'h00, 6'd2, 0, 1, 0, 1);
        add(1, 1, 4'h0, 6'd0, 32'h11, 6'd0, 1, 0, 0, 1);
        add(1, 1, 4'h0, 6'd0, 32'h22, 6'd1, 1, 0, 0, 1);
        add(1, 0, 4'h0, 6'd0, 32'h00, 6'd2, 0, 0, 0, 0);
        add(1, 0, 4'h0, 6'd0, 32'h00, 6'd2, 0, 1, 0, 1);
        // phase 2: BRANCH taken then DISPATCH; BRANCH not taken
        add(2, 1, 4'b0001, 6'd0, 32'h33, 6'd0, 1, 0, 0, 1);
        add(2, 0, 4'b0001, 6'd0, 32'h55, 6'd5, 1, 0, 0, 1);
        add(2, 0, 4'b0000, 6'd9, 32'h99, 6'd9, 0, 0, 0, 0);
        add(2, 0, 4'b0000, 6'd0, 32'h00, 6'd9, 0, 1, 0, 1);
        add(2, 1, 4'b1110, 6'd0, 32'h33, 6'd0, 1, 0, 0, 1);
        add(2, 0, 4'b1110, 6'd0, 32'h44, 6'd1, 0, 0, 0, 0);
        add(2, 0, 4'b1110, 6'd0, 32'h00, 6'd1, 0, 1, 0, 1);
        // phase 3: three nested CALLs overflow a 2-deep stack
        add(3, 1, 4'h0, 6'd0, 32'h01, 6'd0, 1, 0, 0, 1);
        add(3, 0, 4'h0, 6'd0, 32'h0A, 6'd10, 1, 0, 0, 1);
        add(3, 0, 4'h0, 6'd0, 32'h14, 6'd20, 1, 0, 0, 1);
        add(3, 0, 4'h0, 6'd0, 32'h00, 6'd20, 0, 1, 1, 1);
        // phase 4: CALL then RET returns to caller+1
        add(4, 1, 4'h0, 6'd0, 32'h01, 6'd0, 1, 0, 0, 1);
        add(4, 0, 4'h0, 6'd0, 32'h0C, 6'd12, 1, 0, 0, 1);
        add(4, 0, 4'h0, 6'd0, 32'h02, 6'd1, 0, 0, 0, 0);
        add(4, 0, 4'h0, 6'd0, 32'h00, 6'd1, 0, 1, 0, 1);
        // phase 5: RET with empty stack; restart clears err
        add(5, 1, 4'h0, 6'd0, 32'h7E, 6'd0, 1, 0, 0, 1);
        add(5, 0, 4'h0, 6'd0, 32'h00, 6'd0, 0, 1, 1, 1);
        add(5, 1, 4'h0, 6'd0, 32'h7E, 6'd0, 1, 0, 0, 1);
        add(5, 0, 4'h0, 6'd0, 32'h00, 6'd0, 0, 1, 1, 1);
        // phase 6: NEXT wraps 63 -> 0, then reserved op
        add(6, 1, 4'b0010, 6'd0, 32'h70, 6'd0, 1, 0, 0, 1);
        add(6, 0, 4'b0010, 6'd0, 32'h3E, 6'd62, 1, 0, 0, 1);
        add(6, 0, 4'b0000, 6'd0, 32'h3F, 6'd63, 1, 0, 0, 1);
        add(6, 0, 4'b0000, 6'd0, 32'h70, 6'd0, 1, 0, 0, 1);
        add(6, 0, 4'b0000, 6'd0, 32'h71, 6'd1, 0, 0, 0, 0);
        add(6, 0, 4'b0000, 6'd0, 32'h00, 6'd1, 0, 1, 1, 1);

        rst = 1'b1; start = 1'b0; flags = '0; opcode = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ctrl", ctrl_out, 32'h0);
        chk("reset_upc", 32'(upc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_finish", 32'(finish), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        for (int a = 0; a < 64; a++) load(6'(a), 44'h0);

        load(0, mw(0, NEXT, 0, 0, 32'h11));
        load(1, mw(0, NEXT, 0, 0, 32'h22));
        load(2, mw(0, HALT, 0, 0, 32'h00));
        run_phase(1);

        load(0, mw(6'd5, BRANCH, 2'd0, 1'b1, 32'h33));
        load(1, mw(0, HALT, 0, 0, 32'h44));
        load(5, mw(0, DISPATCH, 0, 0, 32'h55));
        load(9, mw(0, HALT, 0, 0, 32'h99));
        run_phase(2);

        load(0, mw(6'd10, CALL, 0, 0, 32'h01));
        load(10, mw(6'd20, CALL, 0, 0, 32'h0A));
        load(20, mw(6'd30, CALL, 0, 0, 32'h14));
        load(30, mw(0, HALT, 0, 0, 32'h1E));
        run_phase(3);

        load(0, mw(6'd12, CALL, 0, 0, 32'h01));
        load(12, mw(0, RET, 0, 0, 32'h0C));
        load(1, mw(0, HALT, 0, 0, 32'h02));
        run_phase(4);

        load(0, mw(0, RET, 0, 0, 32'h7E));
        run_phase(5);

        load(0, mw(6'd62, BRANCH, 2'd1, 1'b1, 32'h70));
        load(62, mw(0, NEXT, 0, 0, 32'h3E));
        load(63, mw(0, NEXT, 0, 0, 32'h3F));
        load(1, mw(0, RSVD, 0, 0, 32'h71));
        run_phase(6);

        // writes during RUN must be dropped
        load(0, mw(0, NEXT, 0, 0, 32'h11));
        load(1, mw(0, NEXT, 0, 0, 32'h22));
        load(2, mw(0, HALT, 0, 0, 32'h00));
        start = 1'b1; edge_step(); start = 1'b0;
        chk("g_run_ctrl0", ctrl_out, 32'h11);
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = mw(0, NEXT, 0, 0, 32'hEE);
        edge_step();
        chk("g_run_upc1", 32'(upc), 32'd1);
        wr_addr = 6'd1;
        edge_step();
        wr_en = 1'b0;
        edge_step();
        chk("g_halted", 32'(finish), 32'd1);
        start = 1'b1; edge_step(); start = 1'b0;
        $display("rerun: upc=%0d ctrl=%h", upc, ctrl_out);
        chk("g_rerun_ctrl0", ctrl_out, 32'h11);
        edge_step();
        chk("g_rerun_ctrl1", ctrl_out, 32'h22);

        // asynchronous reset in the middle of RUN
        rst = 1'b1; #1;
        $display("reset mid-run: ctrl=%h busy=%b", ctrl_out, busy);
        chk("g_rst_ctrl", ctrl_out, 32'h0);
        chk("g_rst_busy", 32'(busy), 32'd0);
        chk("g_rst_upc", 32'(upc), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("g_rst_finish", 32'(finish), 32'd0);
        chk("g_rst_err", 32'(err), 32'd0);
        start = 1'b1; edge_step(); start = 1'b0;
        chk("g_after_rst_ctrl0", ctrl_out, 32'h11);
        edge_step();
        chk("g_after_rst_ctrl1", ctrl_out, 32'h22);
        edge_step();
        edge_step();
        chk("g_after_rst_finish", 32'(finish), 32'd1);

        // start and write to START_ADDR on the same edge in IDLE
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_data = mw(0, NEXT, 0, 0, 32'h5A);
        edge_step();
        start = 1'b0; wr_en = 1'b0;
        $display("start+write: upc=%0d ctrl=%h", upc, ctrl_out);
        chk("g_startwr_ctrl0", ctrl_out, 32'h5A);
        chk("g_startwr_busy", 32'(busy), 32'd1);
        edge_step();
        chk("g_startwr_ctrl1", ctrl_out, 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
